// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end of the pipelined MIPS core.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int          INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_bounds_check.sv
// Combinational fetch-address checker: flags a pc outside the text segment
// [BASE, BASE + INSTR_BYTES*MEMORY_DEPTH) and a misaligned redirect target.
module fetch_bounds_check
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE         = RESET_PC_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  pc_oob,
    output logic                  redirect_misaligned
);

    localparam logic [DATA_WIDTH-1:0] LIMIT = BASE + DATA_WIDTH'(INSTR_BYTES * MEMORY_DEPTH);

    // Range test on the address about to be fetched, alignment test on the target.
    always_comb begin
        pc_oob              = (pc < BASE) || (pc >= LIMIT);
        redirect_misaligned = |redirect_pc[1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the async-read program
// memory and registers the returned word into the IF/ID boundary.
// Optional feature: define FETCH_BOUNDS_CHECK_EN to fault (sticky) and halt on
// an out-of-range pc or a misaligned redirect target; otherwise fault is 0 and
// the pc simply wraps/aliases.
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    output logic [DATA_WIDTH-1:0] if_instruction,
    output logic [DATA_WIDTH-1:0] if_pc_plus4,
    output logic                  if_valid,
    output logic                  running,
    output logic                  fault,
    output logic [15:0]           fetch_count
);

    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(INSTR_BYTES);

    fetch_state_t          state, state_n;
    logic [DATA_WIDTH-1:0] pc;
    logic                  load_start;   // (re)enter FETCH at RESET_PC
    logic                  load_rpc;     // take the redirect target
    logic                  deliver;      // write a valid word into IF/ID
    logic                  bubble;       // invalidate the IF/ID slot
    logic                  fault_evt;    // check failed on this edge
    logic                  pc_oob;
    logic                  rpc_misal;

`ifdef FETCH_BOUNDS_CHECK_EN
    logic fault_q;

    fetch_bounds_check #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .BASE        (RESET_PC)
    ) u_bounds (
        .pc                 (pc),
        .redirect_pc        (redirect_pc),
        .pc_oob             (pc_oob),
        .redirect_misaligned(rpc_misal)
    );

    // Sticky fault: set when a check fails in FETCH, cleared by the next start.
    always_ff @(posedge clk) begin
        if (reset)
            fault_q <= 1'b0;
        else if (fault_evt)
            fault_q <= 1'b1;
        else if (load_start)
            fault_q <= 1'b0;
    end

    assign fault = fault_q;
`else
    assign pc_oob    = 1'b0;
    assign rpc_misal = 1'b0;
    assign fault     = 1'b0;
`endif

    assign mem_addr = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state and datapath controls; priority: bad redirect, halt, redirect, stall.
    always_comb begin
        state_n    = state;
        load_start = 1'b0;
        load_rpc   = 1'b0;
        deliver    = 1'b0;
        bubble     = 1'b0;
        fault_evt  = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_n    = FETCH;
                    load_start = 1'b1;
                end
            end
            FETCH: begin
                if (redirect_valid && rpc_misal) begin
                    fault_evt = 1'b1;
                    bubble    = 1'b1;
                    state_n   = HALTED;
                end else if (halt_req) begin
                    load_rpc = redirect_valid;
                    bubble   = 1'b1;
                    state_n  = HALTED;
                end else if (redirect_valid) begin
                    load_rpc = 1'b1;
                    bubble   = 1'b1;
                end else if (!stall) begin
                    if (pc_oob) begin
                        fault_evt = 1'b1;
                        bubble    = 1'b1;
                        state_n   = HALTED;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // PC, IF/ID register, delivery counter and the registered running flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_instruction <= '0;
            if_pc_plus4    <= '0;
            if_valid       <= 1'b0;
            fetch_count    <= 16'd0;
            running        <= 1'b0;
        end else begin
            running <= (state_n == FETCH);
            if (load_start)
                pc <= RESET_PC;
            if (load_rpc)
                pc <= redirect_pc;
            if (bubble)
                if_valid <= 1'b0;
            if (deliver) begin
                if_instruction <= mem_instruction;
                if_pc_plus4    <= pc + STEP;
                if_valid       <= 1'b1;
                pc             <= pc + STEP;
                fetch_count    <= fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios, then random
// stimulus scored against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 32;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stall, redirect_valid, halt_req;
    logic [31:0] redirect_pc, mem_addr, mem_instruction, if_instruction, if_pc_plus4;
    logic        if_valid, running, fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [DEPTH];
    assign mem_instruction = mem[mem_addr[6:2]];

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .mem_addr       (mem_addr),
        .mem_instruction(mem_instruction),
        .if_instruction (if_instruction),
        .if_pc_plus4    (if_pc_plus4),
        .if_valid       (if_valid),
        .running        (running),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = not started, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_ins, m_p4;
    bit          m_vld, m_fault;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_text(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    task automatic model_step(input bit rs, st, stl, rv, hr, input logic [31:0] rpc);
        if (rs) begin
            m_mode = 0; m_pc = BASE; m_ins = 0; m_p4 = 0; m_vld = 0; m_fault = 0; m_cnt = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = BASE; m_fault = 0;
            end
        end else if (BCHK && rv && rpc[1:0] != 2'b00) begin
            m_fault = 1; m_vld = 0; m_mode = 2;
        end else if (hr) begin
            if (rv) m_pc = rpc;
            m_vld = 0; m_mode = 2;
        end else if (rv) begin
            m_pc = rpc; m_vld = 0;
        end else if (!stl) begin
            if (BCHK && !in_text(m_pc)) begin
                m_fault = 1; m_vld = 0; m_mode = 2;
            end else begin
                m_ins = mem[m_pc[6:2]];
                m_p4  = m_pc + 32'd4;
                m_vld = 1;
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    task automatic check_all();
        chk("mem_addr", mem_addr, m_pc);
        chk("if_instruction", if_instruction, m_ins);
        chk("if_pc_plus4", if_pc_plus4, m_p4);
        chk("if_valid", 32'(if_valid), 32'(m_vld));
        chk("running", 32'(running), 32'(m_mode == 1));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    // One clock: drive inputs, advance the model, sample 1ns after the edge.
    task automatic cyc(input bit rs, st, stl, rv, hr, input logic [31:0] rpc);
        reset = rs; start = st; stall = stl; redirect_valid = rv; halt_req = hr; redirect_pc = rpc;
        model_step(rs, st, stl, rv, hr, rpc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        halt_req = 1'b0; redirect_pc = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h2000_0000 + 32'(i);
        #2;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_addr", mem_addr, 32'h0040_0000);
        cyc(0, 0, 0, 0, 0, 0);                 // idle, nothing happens
        // Start then sequential fetch
        cyc(0, 1, 0, 0, 0, 0);
        chk("start_run", 32'(running), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("w0", if_instruction, 32'h2000_0000);
        chk("w0_p4", if_pc_plus4, 32'h0040_0004);
        cyc(0, 0, 0, 0, 0, 0);
        chk("w1", if_instruction, 32'h2000_0001);
        // Stall three cycles: everything frozen
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("stall_cnt", 32'(fetch_count), 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("w2", if_instruction, 32'h2000_0002);
        // Redirect alongside stall: one bubble then word 4
        cyc(0, 0, 1, 1, 0, 32'h0040_0010);
        chk("redir_bubble", 32'(if_valid), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("w4", if_instruction, 32'h2000_0004);
        chk("w4_p4", if_pc_plus4, 32'h0040_0014);
        // Halt, ignored stall/redirect while halted, restart at word 0
        cyc(0, 0, 0, 0, 1, 0);
        chk("halt_run", 32'(running), 32'd0);
        cyc(0, 0, 1, 1, 0, 32'h0040_0020);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);                 // start in FETCH is ignored
        chk("restart_w0", if_instruction, 32'h2000_0000);
`ifdef FETCH_BOUNDS_CHECK_EN
        cyc(0, 0, 0, 1, 0, 32'h0040_0082);
        chk("bad_fault", 32'(fault), 32'd1);
        chk("bad_vld", 32'(if_valid), 32'd0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("fault_clr", 32'(fault), 32'd0);
`endif
        // Reset while fetching and stalled
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("midrst_vld", 32'(if_valid), 32'd0);
        chk("midrst_cnt", 32'(fetch_count), 32'd0);

        // Random phase with random memory contents
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            if ($urandom_range(0, 15) == 0)
                rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));   // pc wrap
            else
                rpc = BASE + 32'(4 * $urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'(1 + $urandom_range(0, 2));
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0,
                rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
